rename_unit: RTL and testbench

- Clocked, parametrised successor to the combinational renamer. It maps architectural rs1/rs2/rd to physical registers through a speculative RAT and a circular free list.
- Adds a valid/ready handshake, in-order commit reclamation of the old mapping, and a single-cycle flush recovery through a committed RAT.
- Sits between decode and dispatch; the ROB drives the commit and flush ports.

---
 rtl/rename_pkg.sv | 20 ++
 rtl/rename_free_list.sv | 68 ++++++
 rtl/rename_unit.sv | 148 ++++++++++++++
 tb/tb_rename_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared sizing defaults and types for the register renaming slice.
package rename_pkg;

  localparam int ARCH_REGS_DEF = 32;
  localparam int PHYS_REGS_DEF = 64;
  localparam int AW_DEF        = $clog2(ARCH_REGS_DEF);
  localparam int PW_DEF        = $clog2(PHYS_REGS_DEF);

  typedef logic [AW_DEF-1:0] areg_t;
  typedef logic [PW_DEF-1:0] preg_t;

  typedef struct packed {
    preg_t rs1_p;
    preg_t rs2_p;
    preg_t rd_p;
    preg_t old_rd_p;
    logic  rd_wr;
  } renamed_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers with a committed head used to rewind on flush.
module rename_free_list
  import rename_pkg::*;
#(
  parameter int PW        = PW_DEF,
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int FL_DEPTH  = PHYS_REGS_DEF - ARCH_REGS_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pop,
  input  logic          push,
  input  logic [PW-1:0] push_preg,
  input  logic          flush,
  output logic [PW-1:0] head_preg,
  output logic [PW-1:0] count
);

  localparam int IW = $clog2(FL_DEPTH);
  localparam int CW = IW + 1;

  logic [PW-1:0] fl [FL_DEPTH];
  logic [CW-1:0] head;
  logic [CW-1:0] comm_head;
  logic [CW-1:0] tail;
  logic [CW-1:0] used;
  logic          full;
  logic          push_ok;

  assign used      = tail - head;
  assign count     = PW'(used);
  assign full      = (used == CW'(FL_DEPTH));
  // A pop in the same cycle frees the slot the push lands in, so that case is not an overflow.
  assign push_ok   = push && (!full || pop);
  assign head_preg = fl[head[IW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head      <= '0;
      comm_head <= '0;
      tail      <= CW'(FL_DEPTH);
      for (int k = 0; k < FL_DEPTH; k++) begin
        fl[k] <= PW'(ARCH_REGS + k);
      end
    end else begin
      if (push_ok) begin
        fl[tail[IW-1:0]] <= push_preg;
        tail             <= tail + 1'b1;
      end
      if (push) begin
        comm_head <= comm_head + 1'b1;
      end
      // Rewind to the committed head, including a retirement in this same cycle.
      if (flush) begin
        head <= push ? comm_head + 1'b1 : comm_head;
      end else if (pop) begin
        head <= head + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/rename_unit.sv
// Clocked register renamer: speculative and committed RATs, circular free list, valid/ready output stage.
// Define RENAME_BUSY_EN to add the physical-register busy table and source-ready outputs.
module rename_unit
  import rename_pkg::*;
#(
  parameter int ARCH_REGS = ARCH_REGS_DEF,
  parameter int PHYS_REGS = PHYS_REGS_DEF,
  parameter int AW        = $clog2(ARCH_REGS),
  parameter int PW        = $clog2(PHYS_REGS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          in_rd_wr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_rs1_p,
  output logic [PW-1:0] out_rs2_p,
  output logic [PW-1:0] out_rd_p,
  output logic [PW-1:0] out_old_rd_p,
  output logic          out_rd_wr,
  input  logic          commit_valid,
  input  logic          commit_rd_wr,
  input  logic [AW-1:0] commit_arch_rd,
  input  logic [PW-1:0] commit_rd_p,
  input  logic [PW-1:0] commit_old_rd_p,
  input  logic          flush,
`ifdef RENAME_BUSY_EN
  input  logic          wb_valid,
  input  logic [PW-1:0] wb_preg,
  output logic          out_rs1_rdy,
  output logic          out_rs2_rdy,
`endif
  output logic [PW-1:0] free_count
);

  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;

  logic [PW-1:0] spec_rat [ARCH_REGS];
  logic [PW-1:0] comm_rat [ARCH_REGS];
  logic          alloc;
  logic          fire;
  logic          commit_en;
  logic [PW-1:0] fl_head_preg;
  logic [PW-1:0] rs1_p;
  logic [PW-1:0] rs2_p;

  assign alloc     = in_rd_wr && (in_rd != '0);
  assign commit_en = commit_valid && commit_rd_wr && (commit_arch_rd != '0);
  assign in_ready  = (!out_valid || out_ready) && (!alloc || (free_count != '0)) && !flush;
  assign fire      = in_valid && in_ready;
  assign rs1_p     = spec_rat[in_rs1];
  assign rs2_p     = spec_rat[in_rs2];

  rename_free_list #(
    .PW        (PW),
    .ARCH_REGS (ARCH_REGS),
    .FL_DEPTH  (FL_DEPTH)
  ) u_free_list (
    .clk       (clk),
    .rstn      (rstn),
    .pop       (fire && alloc),
    .push      (commit_en),
    .push_preg (commit_old_rd_p),
    .flush     (flush),
    .head_preg (fl_head_preg),
    .count     (free_count)
  );

  // Entry 0 is never written, so x0 keeps mapping to p0 in both tables.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      if (!rstn) begin
        spec_rat[i] <= PW'(i);
        comm_rat[i] <= PW'(i);
      end else begin
        if (commit_en && (commit_arch_rd == AW'(i))) begin
          comm_rat[i] <= commit_rd_p;
        end
        if (flush) begin
          spec_rat[i] <= (commit_en && (commit_arch_rd == AW'(i))) ? commit_rd_p : comm_rat[i];
        end else if (fire && alloc && (in_rd == AW'(i))) begin
          spec_rat[i] <= fl_head_preg;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid    <= 1'b0;
      out_rs1_p    <= '0;
      out_rs2_p    <= '0;
      out_rd_p     <= '0;
      out_old_rd_p <= '0;
      out_rd_wr    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_rs1_p    <= rs1_p;
      out_rs2_p    <= rs2_p;
      out_rd_p     <= alloc ? fl_head_preg : '0;
      out_old_rd_p <= alloc ? spec_rat[in_rd] : '0;
      out_rd_wr    <= alloc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RENAME_BUSY_EN
  logic [PHYS_REGS-1:0] busy;
  logic                 rs1_rdy;
  logic                 rs2_rdy;

  // A same-cycle writeback to the source register bypasses the busy bit.
  assign rs1_rdy = (rs1_p == '0) || !busy[rs1_p] || (wb_valid && (wb_preg == rs1_p));
  assign rs2_rdy = (rs2_p == '0) || !busy[rs2_p] || (wb_valid && (wb_preg == rs2_p));

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      busy <= '0;
    end else begin
      if (wb_valid) begin
        busy[wb_preg] <= 1'b0;
      end
      if (fire && alloc) begin
        busy[fl_head_preg] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_rs1_rdy <= 1'b0;
      out_rs2_rdy <= 1'b0;
    end else if (fire) begin
      out_rs1_rdy <= rs1_rdy;
      out_rs2_rdy <= rs2_rdy;
    end
  end
`endif

endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_rename_unit;
  import rename_pkg::*;

  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int AW        = 5;
  localparam int PW        = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          in_rd_wr;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_rs1_p, out_rs2_p, out_rd_p, out_old_rd_p;
  logic          out_rd_wr;
  logic          commit_valid, commit_rd_wr;
  logic [AW-1:0] commit_arch_rd;
  logic [PW-1:0] commit_rd_p, commit_old_rd_p;
  logic          flush;
  logic [PW-1:0] free_count;
`ifdef RENAME_BUSY_EN
  logic          wb_valid;
  logic [PW-1:0] wb_preg;
  logic          out_rs1_rdy, out_rs2_rdy;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rename_unit #(.ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .AW(AW), .PW(PW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_p(out_rs1_p), .out_rs2_p(out_rs2_p), .out_rd_p(out_rd_p),
    .out_old_rd_p(out_old_rd_p), .out_rd_wr(out_rd_wr),
    .commit_valid(commit_valid), .commit_rd_wr(commit_rd_wr),
    .commit_arch_rd(commit_arch_rd), .commit_rd_p(commit_rd_p),
    .commit_old_rd_p(commit_old_rd_p), .flush(flush),
`ifdef RENAME_BUSY_EN
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .out_rs1_rdy(out_rs1_rdy), .out_rs2_rdy(out_rs2_rdy),
`endif
    .free_count(free_count)
  );

  // Model: free registers in a queue, allocated-but-uncommitted ones in order in a second queue.
  typedef struct { int rd; int p; int old; } infl_t;
  int       m_spec [ARCH_REGS];
  int       m_comm [ARCH_REGS];
  int       q_free [$];
  infl_t    q_infl [$];
  bit       m_busy [PHYS_REGS];
  bit       m_valid;
  renamed_t m_out;
  bit       m_rdy1, m_rdy2;
  bit       exp_ready;
  logic     obs_ready;

  function automatic renamed_t mk(input int a, input int b, input int c, input int d, input int w);
    renamed_t r;
    r.rs1_p = preg_t'(a); r.rs2_p = preg_t'(b); r.rd_p = preg_t'(c);
    r.old_rd_p = preg_t'(d); r.rd_wr = (w != 0);
    return r;
  endfunction

  function automatic renamed_t obs_out();
    return mk(int'(out_rs1_p), int'(out_rs2_p), int'(out_rd_p), int'(out_old_rd_p), int'(out_rd_wr));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ARCH_REGS; i++) begin m_spec[i] = i; m_comm[i] = i; end
    q_free.delete(); q_infl.delete();
    for (int k = 0; k < PHYS_REGS - ARCH_REGS; k++) q_free.push_back(ARCH_REGS + k);
    for (int i = 0; i < PHYS_REGS; i++) m_busy[i] = 1'b0;
    m_valid = 1'b0; m_out = '0; m_rdy1 = 1'b0; m_rdy2 = 1'b0;
  endtask

  task automatic drive_idle();
    in_valid = 0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_wr = 0; out_ready = 1;
    commit_valid = 0; commit_rd_wr = 0; commit_arch_rd = '0; commit_rd_p = '0; commit_old_rd_p = '0;
    flush = 0;
`ifdef RENAME_BUSY_EN
    wb_valid = 0; wb_preg = '0;
`endif
  endtask

  task automatic do_reset();
    drive_idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic set_in(input bit v, input int rs1, input int rs2, input int rd, input bit wr);
    in_valid = v; in_rs1 = AW'(rs1); in_rs2 = AW'(rs2); in_rd = AW'(rd); in_rd_wr = wr;
  endtask

  task automatic set_commit(input bit v, input int rd, input int p, input int old);
    commit_valid = v; commit_rd_wr = v; commit_arch_rd = AW'(rd);
    commit_rd_p = PW'(p); commit_old_rd_p = PW'(old);
  endtask

  // One clock: sample in_ready, advance the model at the edge, return at the following negedge.
  task automatic step();
    bit alloc, fire, cmt;
    int p;
    alloc = in_rd_wr && (in_rd != 0);
    exp_ready = (!m_valid || out_ready) && (!alloc || q_free.size() != 0) && !flush;
    #1 obs_ready = in_ready;
    fire = in_valid && exp_ready;
    cmt = commit_valid && commit_rd_wr && (commit_arch_rd != 0);
    @(posedge clk);
    if (flush) m_valid = 1'b0;
    else if (fire) begin
      m_valid = 1'b1;
      m_out.rs1_p = preg_t'(m_spec[in_rs1]);
      m_out.rs2_p = preg_t'(m_spec[in_rs2]);
      m_out.rd_p = alloc ? preg_t'(q_free[0]) : '0;
      m_out.old_rd_p = alloc ? preg_t'(m_spec[in_rd]) : '0;
      m_out.rd_wr = alloc;
`ifdef RENAME_BUSY_EN
      m_rdy1 = (m_spec[in_rs1] == 0) || !m_busy[m_spec[in_rs1]] || (wb_valid && int'(wb_preg) == m_spec[in_rs1]);
      m_rdy2 = (m_spec[in_rs2] == 0) || !m_busy[m_spec[in_rs2]] || (wb_valid && int'(wb_preg) == m_spec[in_rs2]);
`endif
    end else if (out_ready) m_valid = 1'b0;
    if (cmt) begin
      m_comm[commit_arch_rd] = int'(commit_rd_p);
      if (q_infl.size() > 0) void'(q_infl.pop_front());
      q_free.push_back(int'(commit_old_rd_p));
    end
    p = 0;
    if (fire && alloc) begin
      p = q_free.pop_front();
      q_infl.push_back('{int'(in_rd), p, m_spec[in_rd]});
      m_spec[in_rd] = p;
    end
    if (flush) begin
      m_spec = m_comm;
      for (int i = q_infl.size() - 1; i >= 0; i--) q_free.push_front(q_infl[i].p);
      q_infl.delete();
      for (int i = 0; i < PHYS_REGS; i++) m_busy[i] = 1'b0;
    end else begin
`ifdef RENAME_BUSY_EN
      if (wb_valid) m_busy[wb_preg] = 1'b0;
`endif
      if (fire && alloc) m_busy[p] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (obs_out() !== renamed_t'(0)) begin errors++; $display("[TB] FAIL reset_outs: got %h want 0", obs_out()); end
    checks++; if (free_count !== 6'd32) begin errors++; $display("[TB] FAIL reset_free_count: got %0d want 32", free_count); end
    set_in(0, 0, 0, 5, 1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_no_valid: got %0b want 1", in_ready); end
    drive_idle();
  endtask

  task automatic test_basic();
    do_reset();
    set_in(1, 1, 2, 5, 1); step(); drive_idle();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %0b want 1", out_valid); end
    checks++; if (obs_out() !== mk(1, 2, 32, 5, 1)) begin errors++; $display("[TB] FAIL basic_outs: got %h want %h", obs_out(), mk(1, 2, 32, 5, 1)); end
    checks++; if (free_count !== 6'd31) begin errors++; $display("[TB] FAIL basic_free_count: got %0d want 31", free_count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(1, 0, 0, 5, 1); step();
    checks++; if (obs_out() !== mk(0, 0, 32, 5, 1)) begin errors++; $display("[TB] FAIL b2b_first: got %h want %h", obs_out(), mk(0, 0, 32, 5, 1)); end
    step();
    checks++; if (obs_out() !== mk(0, 0, 33, 32, 1)) begin errors++; $display("[TB] FAIL b2b_second: got %h want %h", obs_out(), mk(0, 0, 33, 32, 1)); end
    set_in(1, 5, 0, 0, 0); step(); drive_idle();
    checks++; if (obs_out() !== mk(33, 0, 0, 0, 0)) begin errors++; $display("[TB] FAIL b2b_reader: got %h want %h", obs_out(), mk(33, 0, 0, 0, 0)); end
  endtask

  task automatic test_full();
    int accepted = 0;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_in(1, ((i + 4) % 31) + 1, 0, ((i + 4) % 31) + 1, 1); step();
      if (obs_ready === 1'b1) accepted++;
    end
    checks++; if (accepted != 32) begin errors++; $display("[TB] FAIL full_accepts: got %0d want 32", accepted); end
    checks++; if (free_count !== 6'd0) begin errors++; $display("[TB] FAIL full_count: got %0d want 0", free_count); end
    set_in(1, 0, 0, 7, 1); step();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_blocks: got %0b want 0", obs_ready); end
    set_in(1, 5, 0, 7, 0); step();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_nonwrite_ready: got %0b want 1", obs_ready); end
    checks++; if (obs_out() !== mk(63, 0, 0, 0, 0)) begin errors++; $display("[TB] FAIL full_nonwrite: got %h want %h", obs_out(), mk(63, 0, 0, 0, 0)); end
    set_in(1, 0, 0, 7, 1); set_commit(1, 5, 32, 5); step();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_commit_cycle: got %0b want 0", obs_ready); end
    set_commit(0, 0, 0, 0); step(); drive_idle();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_reopen: got %0b want 1", obs_ready); end
    checks++; if (obs_out() !== mk(0, 0, 5, 34, 1)) begin errors++; $display("[TB] FAIL full_reuse: got %h want %h", obs_out(), mk(0, 0, 5, 34, 1)); end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1, 0, 0, 3, 1); step();
    set_in(1, 0, 0, 4, 1); step();
    drive_idle(); set_commit(1, 3, 32, 3); step();
    drive_idle(); flush = 1; step(); flush = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %0b want 0", out_valid); end
    checks++; if (free_count !== 6'd32) begin errors++; $display("[TB] FAIL flush_count: got %0d want 32", free_count); end
    set_in(1, 3, 4, 0, 0); step();
    checks++; if (obs_out() !== mk(32, 4, 0, 0, 0)) begin errors++; $display("[TB] FAIL flush_rat: got %h want %h", obs_out(), mk(32, 4, 0, 0, 0)); end
    set_in(1, 0, 0, 6, 1); step(); drive_idle();
    checks++; if (obs_out() !== mk(0, 0, 33, 6, 1)) begin errors++; $display("[TB] FAIL flush_realloc: got %h want %h", obs_out(), mk(0, 0, 33, 6, 1)); end
    checks++; if (free_count !== 6'd31) begin errors++; $display("[TB] FAIL flush_realloc_count: got %0d want 31", free_count); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    out_ready = 0; set_in(1, 1, 2, 5, 1); step();
    set_in(1, 3, 0, 6, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready c%0d: got %0b want 0", c, obs_ready); end
      checks++; if (out_valid !== 1'b1 || obs_out() !== mk(1, 2, 32, 5, 1)) begin errors++; $display("[TB] FAIL stall_hold c%0d: got %b/%h want 1/%h", c, out_valid, obs_out(), mk(1, 2, 32, 5, 1)); end
    end
    out_ready = 1; set_commit(1, 5, 32, 5); step(); set_commit(0, 0, 0, 0);
    checks++; if (obs_out() !== mk(3, 0, 33, 6, 1)) begin errors++; $display("[TB] FAIL fire_commit_outs: got %h want %h", obs_out(), mk(3, 0, 33, 6, 1)); end
    checks++; if (free_count !== 6'd31) begin errors++; $display("[TB] FAIL fire_commit_count: got %0d want 31", free_count); end
    set_in(0, 0, 0, 0, 0); out_ready = 0; flush = 1; step(); flush = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_flush: got %0b want 0", out_valid); end
    set_in(1, 1, 0, 9, 1); step();
    do_reset();
    checks++; if (out_valid !== 1'b0 || obs_out() !== renamed_t'(0)) begin errors++; $display("[TB] FAIL stall_reset: got %b/%h want 0/0", out_valid, obs_out()); end
  endtask

`ifdef RENAME_BUSY_EN
  task automatic test_busy();
    do_reset();
    set_in(1, 1, 0, 5, 1); step();
    checks++; if (out_rs1_rdy !== 1'b1 || out_rs2_rdy !== 1'b1) begin errors++; $display("[TB] FAIL busy_init: got %b%b want 11", out_rs1_rdy, out_rs2_rdy); end
    set_in(1, 5, 5, 0, 0); step();
    checks++; if (out_rs1_rdy !== 1'b0 || out_rs2_rdy !== 1'b0) begin errors++; $display("[TB] FAIL busy_set: got %b%b want 00", out_rs1_rdy, out_rs2_rdy); end
    set_in(1, 5, 0, 0, 0); wb_valid = 1; wb_preg = 6'd32; step(); wb_valid = 0;
    checks++; if (out_rs1_rdy !== 1'b1) begin errors++; $display("[TB] FAIL busy_bypass: got %b want 1", out_rs1_rdy); end
    step();
    checks++; if (out_rs1_rdy !== 1'b1) begin errors++; $display("[TB] FAIL busy_cleared: got %b want 1", out_rs1_rdy); end
    set_in(1, 0, 0, 6, 1); wb_valid = 1; wb_preg = 6'd33; step(); wb_valid = 0;
    set_in(1, 6, 0, 0, 0); step(); drive_idle();
    checks++; if (out_rs1_rdy !== 1'b0) begin errors++; $display("[TB] FAIL busy_alloc_wins: got %b want 0", out_rs1_rdy); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      if (q_infl.size() > 0 && $urandom_range(0, 2) == 0)
        set_commit(1, q_infl[0].rd, q_infl[0].p, q_infl[0].old);
      else begin
        set_commit(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        commit_valid = ($urandom_range(0, 7) == 0);
      end
`ifdef RENAME_BUSY_EN
      wb_valid = ($urandom_range(0, 1) != 0); wb_preg = PW'($urandom_range(0, 63));
`endif
      step();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("[TB] FAIL rnd_ready c%0d: got %b want %b", c, obs_ready, exp_ready); end
      checks++; if (out_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", c, out_valid, m_valid); end
      checks++; if (obs_out() !== m_out) begin errors++; $display("[TB] FAIL rnd_outs c%0d: got %h want %h", c, obs_out(), m_out); end
      checks++; if (int'(free_count) != q_free.size()) begin errors++; $display("[TB] FAIL rnd_count c%0d: got %0d want %0d", c, free_count, q_free.size()); end
`ifdef RENAME_BUSY_EN
      checks++; if (out_rs1_rdy !== m_rdy1 || out_rs2_rdy !== m_rdy2) begin errors++; $display("[TB] FAIL rnd_rdy c%0d: got %b%b want %b%b", c, out_rs1_rdy, out_rs2_rdy, m_rdy1, m_rdy2); end
`endif
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_full();
    test_flush();
    test_back_pressure();
`ifdef RENAME_BUSY_EN
    test_busy();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
